tnn_result_ddr_writer: RTL
==========================

// Module: tnn_result_ddr_writer
// PURPOSE
// - Downstream of the TNN result path. Drains the 512-bit result stream (valid/ready, aclk domain) into a
//   host-visible DDR ring buffer over an AXI4 write-master port.
// - Counts images once their data is durably written (B response received) and reports status for CSRs.
// PARAMETERS
// - BURST_BEATS   8    beats per AXI burst; 1..16; BURST_BYTES = 64*BURST_BEATS must divide 4096
// - IMG_BEATS     16   512-bit result beats per image; multiple of BURST_BEATS
// - MAX_OUT       4    max outstanding write bursts awaiting B response; 1..15
// PORTS
// - aclk         in   1    clock
// - srst         in   1    synchronous active-high reset
// - enable       in   1    1 = may issue new bursts; 0 = finish current burst, then idle
// - cfg_base     in   64   ring base byte address; BURST_BYTES aligned
// - cfg_size     in   32   ring size in bytes; multiple of BURST_BYTES, >= 2*BURST_BYTES
// - in_bits      in   512  result beat
// - in_vld       in   1    result beat valid
// - in_rdy       out  1    result beat accepted when in_vld & in_rdy
// - awaddr       out  64   cfg_base + wr_off
// - awlen        out  8    constant BURST_BEATS-1
// - awsize       out  3    constant 3'b110 (64 B); awburst INCR implied
// - awvalid      out  1
// - awready      in   1
// - wdata        out  512  = in_bits
// - wstrb        out  64   constant all ones
// - wlast        out  1
// - wvalid       out  1    = in_vld while in DATA
// - wready       in   1
// - bresp        in   2
// - bvalid       in   1
// - bready       out  1    constant 1
// - wr_off       out  32   byte offset of next burst within ring
// - img_count    out  32   images completely written and acknowledged; wraps at 2^32
// - err          out  1    sticky; set on any bresp != 2'b00
// - busy         out  1    state != IDLE or outstanding != 0
// BEHAVIOUR
// - Reset: state IDLE; awvalid=wvalid=wlast=in_rdy=0; wr_off=0; img_count=0; err=0; outstanding=0;
//   beat_cnt=0; resp_cnt=0. srst may arrive mid-burst; the AXI interconnect is reset in the same cycle.
// - FSM IDLE: if enable & in_vld & outstanding<MAX_OUT -> ADDR (awvalid=1 next cycle, awaddr registered).
// - ADDR: awvalid held, awaddr stable until awready; on awready -> DATA, outstanding+1.
// - DATA: wvalid=in_vld, in_rdy=wready (combinational pass-through, zero added latency); beat_cnt+1 per
//   handshake; wlast = (beat_cnt==BURST_BEATS-1). Last handshake -> IDLE, beat_cnt=0,
//   wr_off = (wr_off+BURST_BYTES==cfg_size) ? 0 : wr_off+BURST_BYTES.
// - in_rdy=0 outside DATA; gaps in in_vld within a burst are legal (wvalid drops).
// - enable deassert mid-burst: burst completes; no new AW issued.
// - B channel: bready=1; each bvalid decrements outstanding; same-cycle AW handshake and bvalid leave it
//   unchanged. resp_cnt counts B responses modulo IMG_BEATS/BURST_BEATS; on wrap img_count+1.
// - err is set on the cycle after a bad bresp; the response still counts toward img_count. Cleared only by srst.
// - cfg_base/cfg_size changed only while enable=0 and busy=0; otherwise behaviour is undefined.
// CONFIGURATION
// - TNN_WR_RING_GUARD_EN defined: extra input host_rd_off [31:0] (host consumer byte offset). IDLE->ADDR is
//   additionally blocked while next_wr_off == host_rd_off (ring full, one burst kept empty); in_rdy stays 0.
// - Undefined: no host_rd_off port; the writer overwrites unread ring data freely.
// TESTING
// - cfg_size=1024, 16 beats, awready/wready=1, immediate B -> 2 AW at base+0, base+512; wlast on beats 8,16;
//   img_count=1; wr_off=0.
// - Random wready stalls, in_vld gaps -> wdata order equals input order; awaddr stable while awvalid & !awready.
// - bvalid withheld, MAX_OUT=4, continuous input -> exactly 4 AW issued, in_rdy=0; release one B -> 5th AW.
// - bresp=2'b10 on 2nd response -> err=1 next cycle, img_count still reaches 1, err persists until srst.
// - srst mid-DATA at beat 3 -> next cycle awvalid=wvalid=0, wr_off=0, img_count=0, busy=0.
// - With TNN_WR_RING_GUARD_EN, cfg_size=1024, host_rd_off=0 -> one burst written, then stall;
//   host_rd_off=512 -> 2nd burst to base+512, then stall again.

Source files
------------

// File: rtl/tnn_result_ddr_writer_if.sv
// Result-stream input plus AXI4 write-channel bundle for tnn_result_ddr_writer.
// The master modport is the writer's view; the slave modport is the source/interconnect view.
interface tnn_result_ddr_writer_if;
  logic [511:0] in_bits;
  logic         in_vld;
  logic         in_rdy;

  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;

  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  modport master (
    input  in_bits, in_vld,
    output in_rdy,
    output awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output in_bits, in_vld,
    input  in_rdy,
    input  awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/tnn_result_ddr_writer.sv
// Drains the 512-bit TNN result stream into a DDR ring buffer via AXI4 write bursts.
// Optional macro TNN_WR_RING_GUARD_EN adds host_rd_off and stops before overrunning the reader.
module tnn_result_ddr_writer #(
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned IMG_BEATS   = 16,
  parameter int unsigned MAX_OUT     = 4
) (
  input  logic        aclk,
  input  logic        srst,
  input  logic        enable,
  input  logic [63:0] cfg_base,
  input  logic [31:0] cfg_size,
`ifdef TNN_WR_RING_GUARD_EN
  input  logic [31:0] host_rd_off,
`endif
  tnn_result_ddr_writer_if.master bus,
  output logic [31:0] wr_off,
  output logic [31:0] img_count,
  output logic        err,
  output logic        busy
);

  localparam logic [31:0] BurstBytes = 32'(64 * BURST_BEATS);
  localparam logic [4:0]  LastBeat   = 5'(BURST_BEATS - 1);
  localparam logic [15:0] LastResp   = 16'((IMG_BEATS / BURST_BEATS) - 1);
  localparam logic [3:0]  MaxOut     = 4'(MAX_OUT);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic [63:0] awaddr_q, awaddr_d;
  logic [31:0] wr_off_q, wr_off_d, next_wr_off;
  logic [4:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [15:0] resp_cnt_q, resp_cnt_d;
  logic [31:0] img_count_q, img_count_d;
  logic        err_q, err_d;
  logic        aw_hs, w_hs, may_issue;

  assign next_wr_off = (wr_off_q + BurstBytes == cfg_size) ? 32'd0 : wr_off_q + BurstBytes;

`ifdef TNN_WR_RING_GUARD_EN
  // One burst slot stays empty so a full ring is distinguishable from an empty one.
  assign may_issue = enable && bus.in_vld && (outstanding_q < MaxOut) &&
                     (next_wr_off != host_rd_off);
`else
  assign may_issue = enable && bus.in_vld && (outstanding_q < MaxOut);
`endif

  assign bus.awaddr  = awaddr_q;
  assign bus.awlen   = 8'(BURST_BEATS - 1);
  assign bus.awsize  = 3'b110;
  assign bus.awvalid = (state_q == StAddr);
  assign bus.wdata   = bus.in_bits;
  assign bus.wstrb   = '1;
  assign bus.wvalid  = (state_q == StData) && bus.in_vld;
  assign bus.in_rdy  = (state_q == StData) && bus.wready;
  assign bus.wlast   = (state_q == StData) && (beat_cnt_q == LastBeat);
  assign bus.bready  = 1'b1;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  assign wr_off    = wr_off_q;
  assign img_count = img_count_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle) || (outstanding_q != 4'd0);

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    wr_off_d   = wr_off_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (may_issue) begin
          state_d  = StAddr;
          awaddr_d = cfg_base + {32'd0, wr_off_q};
        end
      end
      StAddr: begin
        if (bus.awready) state_d = StData;
      end
      StData: begin
        if (w_hs) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StIdle;
            beat_cnt_d = 5'd0;
            wr_off_d   = next_wr_off;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response bookkeeping: an image counts once all of its bursts are acknowledged.
  always_comb begin
    outstanding_d = outstanding_q;
    resp_cnt_d    = resp_cnt_q;
    img_count_d   = img_count_q;
    err_d         = err_q;
    unique case ({aw_hs, bus.bvalid})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
    if (bus.bvalid) begin
      if (bus.bresp != 2'b00) err_d = 1'b1;
      if (resp_cnt_q == LastResp) begin
        resp_cnt_d  = 16'd0;
        img_count_d = img_count_q + 32'd1;
      end else begin
        resp_cnt_d = resp_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q       <= StIdle;
      awaddr_q      <= 64'd0;
      wr_off_q      <= 32'd0;
      beat_cnt_q    <= 5'd0;
      outstanding_q <= 4'd0;
      resp_cnt_q    <= 16'd0;
      img_count_q   <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      awaddr_q      <= awaddr_d;
      wr_off_q      <= wr_off_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
      resp_cnt_q    <= resp_cnt_d;
      img_count_q   <= img_count_d;
      err_q         <= err_d;
    end
  end

endmodule
